// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_pkg : shared types and constants for the load/store unit             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_MEM_WORDS = 256;

  // Only funct3 codes that name a real access for the given direction are legal.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_align : little-endian lane extract/extend and byte/half store merge  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr_lo)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata = word;
    case (funct3)
      F3_B:    rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    rdata = {{16{w_half[15]}}, w_half};
      F3_BU:   rdata = {24'h000000, w_byte};
      F3_HU:   rdata = {16'h0000, w_half};
      default: rdata = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit : single-outstanding load/store initiator with RMW for   |
// |                   byte/half stores to a word-only memory. Rev 1.0        |
// +--------------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

  lsu_state_t  r_state;
  lsu_state_t  w_next;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_wword;
  logic [31:0] r_mem_addr;

  logic        w_accept;
  logic        w_misalign;
  logic        w_range;
  logic        w_req_err;
  logic [31:0] w_extract;
  logic [31:0] w_merged;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_misalign = ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) ||
                      (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]);
  assign w_range    = ({2'b00, req_addr[31:2]} >= c_mem_words);
  assign w_req_err  = w_misalign || w_range || !f3_legal(req_we, req_funct3);

  lsu_align u_align (
    .word    (mem_read_data),
    .addr_lo (r_addr_lo),
    .funct3  (r_f3),
    .wdata   (r_wdata),
    .rdata   (w_extract),
    .merged  (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                           w_next = S_RESP;
          else if (req_we && (req_funct3 == F3_W)) w_next = S_WR;
          else                                     w_next = S_RD;
        end
      end
      S_RD:    w_next = S_RDW;
      S_RDW:   w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (r_state == S_IDLE);
    mem_memread    = (r_state == S_RD);
    mem_memwrite   = (r_state == S_WR);
    mem_write_data = (r_state == S_WR) ? r_wword : 32'h0;
    mem_addr       = r_mem_addr;
    resp_valid     = (r_state == S_RESP);
    resp_err       = (r_state == S_RESP) && r_err;
    resp_rdata     = (r_state == S_RESP) ? r_rdata : 32'h0;
  end

  // Request capture on accept; RDW either latches the load result or the merged store word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we       <= 1'b0;
      r_f3       <= 3'b000;
      r_addr_lo  <= 2'b00;
      r_wdata    <= 32'h0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_wword    <= 32'h0;
      r_mem_addr <= 32'h0;
    end else begin
      if (w_accept) begin
        r_we      <= req_we;
        r_f3      <= req_funct3;
        r_addr_lo <= req_addr[1:0];
        r_wdata   <= req_wdata;
        r_err     <= w_req_err;
        r_rdata   <= 32'h0;
        r_wword   <= req_wdata;
        // Rejected requests never reach the memory, so the address bus keeps its old value.
        if (!w_req_err) r_mem_addr <= {2'b00, req_addr[31:2]};
      end
      if (r_state == S_RDW) begin
        if (r_we) r_wword <= w_merged;
        else      r_rdata <= w_extract;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit : directed vector table plus reset and back-to-back   |
// |                      sequences against a registered-read memory model    |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data = 32'h0;

  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_addr[7:0]] <= mem_write_data;
    if (mem_memread)  mem_read_data <= mem[mem_addr[7:0]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          rd_cyc;
    logic [31:0] rd_addr;
    int          wr_cyc;
    logic [31:0] wr_data;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request from just after an edge and observes it until resp_valid (bounded).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                         output logic err, output int rd_cyc, output logic [31:0] rd_addr,
                         output int wr_cyc, output logic [31:0] wr_data, output int both);
    lat = -1; rdata = 32'hX; err = 1'bx;
    rd_cyc = 0; rd_addr = 32'h0; wr_cyc = 0; wr_data = 32'h0; both = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_memread && rd_cyc == 0) begin rd_cyc = k; rd_addr = mem_addr; end
      if (mem_memwrite && wr_cyc == 0) begin wr_cyc = k; wr_data = mem_write_data; end
      if (mem_memread && mem_memwrite) both = 1;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, rd_cyc, wr_cyc, both;
    logic [31:0] rdata, rd_addr, wr_data;
    logic err;
    logic wr_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1]   = 32'd32;
    mem[2]   = 32'd20;
    mem[5]   = 32'h1122_3344;
    mem[255] = 32'hCAFE_F00D;

    //            we    f3      addr       wdata         lat rdata          err  rdc rda    wrc wrd
    vecs[0]  = '{1'b0, F3_W,  32'h4,   32'hFFFF_FFFF, 3, 32'h0000_0020, 1'b0, 1, 32'd1,   0, 32'h0};
    vecs[1]  = '{1'b1, F3_B,  32'h9,   32'h0000_00AB, 4, 32'h0,         1'b0, 1, 32'd2,   3, 32'h0000_AB14};
    vecs[2]  = '{1'b0, F3_B,  32'h9,   32'hFFFF_FFFF, 3, 32'hFFFF_FFAB, 1'b0, 1, 32'd2,   0, 32'h0};
    vecs[3]  = '{1'b0, F3_BU, 32'h9,   32'hFFFF_FFFF, 3, 32'h0000_00AB, 1'b0, 1, 32'd2,   0, 32'h0};
    vecs[4]  = '{1'b1, F3_H,  32'hA,   32'h0000_8001, 4, 32'h0,         1'b0, 1, 32'd2,   3, 32'h8001_AB14};
    vecs[5]  = '{1'b0, F3_H,  32'hA,   32'hFFFF_FFFF, 3, 32'hFFFF_8001, 1'b0, 1, 32'd2,   0, 32'h0};
    vecs[6]  = '{1'b0, F3_HU, 32'hA,   32'hFFFF_FFFF, 3, 32'h0000_8001, 1'b0, 1, 32'd2,   0, 32'h0};
    vecs[7]  = '{1'b0, F3_W,  32'h8,   32'hFFFF_FFFF, 3, 32'h8001_AB14, 1'b0, 1, 32'd2,   0, 32'h0};
    vecs[8]  = '{1'b0, F3_W,  32'h6,   32'hFFFF_FFFF, 1, 32'h0,         1'b1, 0, 32'd0,   0, 32'h0};
    vecs[9]  = '{1'b1, F3_W,  32'h400, 32'h1234_5678, 1, 32'h0,         1'b1, 0, 32'd0,   0, 32'h0};
    vecs[10] = '{1'b0, 3'b011, 32'h4,  32'hFFFF_FFFF, 1, 32'h0,         1'b1, 0, 32'd0,   0, 32'h0};
    vecs[11] = '{1'b1, F3_W,  32'h10,  32'hDEAD_BEEF, 2, 32'h0,         1'b0, 0, 32'd0,   1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, F3_B,  32'h13,  32'hFFFF_FFFF, 3, 32'hFFFF_FFDE, 1'b0, 1, 32'd4,   0, 32'h0};
    vecs[13] = '{1'b0, F3_HU, 32'h10,  32'hFFFF_FFFF, 3, 32'h0000_BEEF, 1'b0, 1, 32'd4,   0, 32'h0};
    vecs[14] = '{1'b1, F3_H,  32'h3,   32'h0000_FFFF, 1, 32'h0,         1'b1, 0, 32'd0,   0, 32'h0};
    vecs[15] = '{1'b1, 3'b011, 32'h0,  32'h0000_0001, 1, 32'h0,         1'b1, 0, 32'd0,   0, 32'h0};
    vecs[16] = '{1'b0, F3_W,  32'h3FC, 32'hFFFF_FFFF, 3, 32'hCAFE_F00D, 1'b0, 1, 32'd255, 0, 32'h0};
    vecs[17] = '{1'b0, F3_B,  32'h12,  32'hFFFF_FFFF, 3, 32'hFFFF_FFAD, 1'b0, 1, 32'd4,   0, 32'h0};
    vecs[18] = '{1'b0, F3_BU, 32'h10,  32'hFFFF_FFFF, 3, 32'h0000_00EF, 1'b0, 1, 32'd4,   0, 32'h0};

    #1;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_write_data", mem_write_data, 32'h0);
    chk("rst strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      chk($sformatf("v%0d req_ready", i), {31'h0, req_ready}, 32'h1);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              lat, rdata, err, rd_cyc, rd_addr, wr_cyc, wr_data, both);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d resp_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("v%0d resp_err", i), {31'h0, err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d memread cycle", i), rd_cyc, vecs[i].rd_cyc);
      if (vecs[i].rd_cyc != 0) chk($sformatf("v%0d mem_addr", i), rd_addr, vecs[i].rd_addr);
      chk($sformatf("v%0d memwrite cycle", i), wr_cyc, vecs[i].wr_cyc);
      if (vecs[i].wr_cyc != 0) chk($sformatf("v%0d mem_write_data", i), wr_data, vecs[i].wr_data);
      chk($sformatf("v%0d both strobes", i), both, 0);
    end
    chk("mem[2] after RMW", mem[2], 32'h8001_AB14);

    // Reset asserted while an SB is in its read cycle.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h14; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw rst RD memread", {31'h0, mem_memread}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rmw rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rmw rst strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    chk("rmw rst mem_addr", mem_addr, 32'h0);
    chk("rmw rst resp", {31'h0, resp_valid}, 32'h0);
    wr_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_seen = wr_seen | mem_memwrite;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_seen = wr_seen | mem_memwrite;
    end
    chk("rmw rst no memwrite", {31'h0, wr_seen}, 32'h0);
    chk("rmw rst mem[5]", mem[5], 32'h1122_3344);
    chk("post rst req_ready", {31'h0, req_ready}, 32'h1);
    run_req(1'b1, F3_W, 32'h0, 32'd7, lat, rdata, err, rd_cyc, rd_addr, wr_cyc, wr_data, both);
    chk("post rst SW latency", lat, 2);
    chk("post rst SW wdata", wr_data, 32'd7);
    chk("post rst SW err", {31'h0, err}, 32'h0);
    chk("post rst mem[0]", mem[0], 32'd7);

    // Back-to-back: valid held high, SW then LW to word 8.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'd7;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      case (k)
        1: chk("b2b SW memwrite", {31'h0, mem_memwrite}, 32'h1);
        2: chk("b2b SW resp", {30'h0, resp_valid, resp_err}, 32'h2);
        3: chk("b2b idle ready", {31'h0, req_ready}, 32'h1);
        4: begin
          chk("b2b LW accepted", {30'h0, req_ready, mem_memread}, 32'h1);
          chk("b2b LW mem_addr", mem_addr, 32'd8);
          req_valid = 1'b0;
        end
        5: chk("b2b RDW no resp", {31'h0, resp_valid}, 32'h0);
        default: begin
          chk("b2b LW resp", {30'h0, resp_valid, resp_err}, 32'h2);
          chk("b2b LW rdata", resp_rdata, 32'd7);
        end
      endcase
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
